// File: rtl/traffic_ctrl_param.sv
// Traffic-light controller: main/side/pedestrian lamps sequenced by a state FSM,
// with programmable phase durations counted in divided clock ticks.
module traffic_ctrl_param #(
  parameter int unsigned TIME_W   = 4,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned DEF_BASE = 6,
  parameter int unsigned DEF_EXT  = 3,
  parameter int unsigned DEF_YEL  = 2,
  parameter int unsigned DEF_WALK = 3
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Sensor,
  input  logic              Walk_Request,
  input  logic              Reprogram,
  input  logic [1:0]        Time_Parameter_Selector,
  input  logic [TIME_W-1:0] Time_Value,
  output logic [6:0]        LEDs,
  output logic              Walk_Pending,
  output logic [2:0]        Phase
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    MG1  = 3'd0,
    MG2  = 3'd1,
    MY   = 3'd2,
    WALK = 3'd3,
    SG   = 3'd4,
    SY   = 3'd5
  } state_t;

  state_t            state;
  logic [TIME_W-1:0] t_base, t_ext, t_yel, t_walk;
  logic [TIME_W-1:0] timer;
  logic [DIV_W-1:0]  div;
  logic              pending;
  logic              ext_used;
  logic              tick;

  // A stored duration of zero still occupies one tick in the timer.
  function automatic logic [TIME_W-1:0] clamp(input logic [TIME_W-1:0] d);
    return (d == '0) ? TIME_W'(1) : d;
  endfunction

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (Reset) begin
      t_base   <= TIME_W'(DEF_BASE);
      t_ext    <= TIME_W'(DEF_EXT);
      t_yel    <= TIME_W'(DEF_YEL);
      t_walk   <= TIME_W'(DEF_WALK);
      state    <= MG1;
      timer    <= clamp(TIME_W'(DEF_BASE));
      div      <= '0;
      pending  <= 1'b0;
      ext_used <= 1'b0;
    end else if (Reprogram) begin
      case (Time_Parameter_Selector)
        2'b00:   t_base <= Time_Value;
        2'b01:   t_ext  <= Time_Value;
        2'b10:   t_yel  <= Time_Value;
        default: t_walk <= Time_Value;
      endcase
      state    <= MG1;
      timer    <= (Time_Parameter_Selector == 2'b00) ? clamp(Time_Value) : clamp(t_base);
      div      <= '0;
      ext_used <= 1'b0;
      pending  <= pending | Walk_Request;
    end else begin
      div     <= tick ? '0 : div + DIV_W'(1);
      pending <= pending | Walk_Request;
      if (tick) begin
        if (timer == TIME_W'(1)) begin
          case (state)
            MG1: begin
              state <= MG2;
              timer <= Sensor ? clamp(t_ext) : clamp(t_base);
            end
            MG2: begin
              state <= MY;
              timer <= clamp(t_yel);
            end
            MY: begin
              if (pending | Walk_Request) begin
                state   <= WALK;
                timer   <= clamp(t_walk);
                pending <= Walk_Request;
              end else begin
                state    <= SG;
                timer    <= clamp(t_base);
                ext_used <= 1'b0;
              end
            end
            WALK: begin
              state    <= SG;
              timer    <= clamp(t_base);
              ext_used <= 1'b0;
            end
            SG: begin
              if (Sensor && !ext_used) begin
                timer    <= clamp(t_ext);
                ext_used <= 1'b1;
              end else begin
                state <= SY;
                timer <= clamp(t_yel);
              end
            end
            SY: begin
              state <= MG1;
              timer <= clamp(t_base);
            end
            default: begin
              state <= MG1;
              timer <= clamp(t_base);
            end
          endcase
        end else begin
          timer <= timer - TIME_W'(1);
        end
      end
    end
  end

  always_comb begin
    LEDs = 7'b0011000;
    case (state)
      MG1, MG2: LEDs = 7'b0011000;
      MY:       LEDs = 7'b0101000;
      WALK:     LEDs = 7'b1001001;
      SG:       LEDs = 7'b1000010;
      SY:       LEDs = 7'b1000100;
      default:  LEDs = 7'b0011000;
    endcase
  end

  assign Phase        = state;
  assign Walk_Pending = pending;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param: phase durations, walk, sensor extension,
// reprogramming, zero clamp and a divided-tick instance.
module tb_traffic_ctrl_param;

  logic       clk = 1'b0;
  logic       reset, sensor, walk_request, reprogram;
  logic [1:0] sel;
  logic [3:0] time_value;
  logic [6:0] leds;
  logic       walk_pending;
  logic [2:0] phase;

  logic       reset4;
  logic [6:0] leds4;
  logic       walk_pending4;
  logic [2:0] phase4;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  traffic_ctrl_param #(.TIME_W(4), .TICK_DIV(1)) dut (
    .clk(clk), .Reset(reset), .Sensor(sensor), .Walk_Request(walk_request),
    .Reprogram(reprogram), .Time_Parameter_Selector(sel), .Time_Value(time_value),
    .LEDs(leds), .Walk_Pending(walk_pending), .Phase(phase)
  );

  traffic_ctrl_param #(.TIME_W(4), .TICK_DIV(4)) dut4 (
    .clk(clk), .Reset(reset4), .Sensor(1'b0), .Walk_Request(1'b0),
    .Reprogram(1'b0), .Time_Parameter_Selector(2'b00), .Time_Value(4'd0),
    .LEDs(leds4), .Walk_Pending(walk_pending4), .Phase(phase4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect the main DUT to sit in one phase for n samples with the given lamps.
  task automatic run_phase(input string tag, input logic [2:0] ph, input logic [6:0] lamps,
                           input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check({tag, "_phase"}, 32'(phase), 32'(ph));
      if (i == 0) check({tag, "_leds"}, 32'(leds), 32'(lamps));
      step();
    end
  endtask

  task automatic count_phase4(input logic [2:0] ph, output int unsigned n);
    n = 0;
    while (phase4 == ph && n < 200) begin
      n++;
      step();
    end
  endtask

  localparam logic [6:0] L_MG = 7'b0011000;
  localparam logic [6:0] L_MY = 7'b0101000;
  localparam logic [6:0] L_WK = 7'b1001001;
  localparam logic [6:0] L_SG = 7'b1000010;
  localparam logic [6:0] L_SY = 7'b1000100;

  initial begin
    int unsigned n;
    reset = 1'b1; reset4 = 1'b1; sensor = 1'b0; walk_request = 1'b0;
    reprogram = 1'b0; sel = 2'b00; time_value = 4'd0;
    step();
    reset = 1'b0; reset4 = 1'b0;

    // Reset state and idle cycle
    check("rst_leds", 32'(leds), 32'(L_MG));
    check("rst_pend", 32'(walk_pending), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    run_phase("idle_mg1", 3'd0, L_MG, 6);
    run_phase("idle_mg2", 3'd1, L_MG, 6);
    run_phase("idle_my", 3'd2, L_MY, 2);
    run_phase("idle_sg", 3'd4, L_SG, 6);
    run_phase("idle_sy", 3'd5, L_SY, 2);
    check("idle_wrap", 32'(phase), 32'd0);

    // Pedestrian pulse during MG1
    walk_request = 1'b1;
    step();
    walk_request = 1'b0;
    check("walk_pend_set", 32'(walk_pending), 32'd1);
    run_phase("walk_mg1", 3'd0, L_MG, 5);
    run_phase("walk_mg2", 3'd1, L_MG, 6);
    run_phase("walk_my", 3'd2, L_MY, 2);
    check("walk_pend_clr", 32'(walk_pending), 32'd0);
    run_phase("walk_walk", 3'd3, L_WK, 3);
    run_phase("walk_sg", 3'd4, L_SG, 6);
    run_phase("walk_sy", 3'd5, L_SY, 2);

    // Sensor held: MG2 uses tEXT, SG extended exactly once
    sensor = 1'b1;
    run_phase("sens_mg1", 3'd0, L_MG, 6);
    run_phase("sens_mg2", 3'd1, L_MG, 3);
    run_phase("sens_my", 3'd2, L_MY, 2);
    run_phase("sens_sg", 3'd4, L_SG, 9);
    run_phase("sens_sy", 3'd5, L_SY, 2);
    sensor = 1'b0;

    // Reprogram tYEL=5 in the middle of SG
    run_phase("rp_mg1", 3'd0, L_MG, 6);
    run_phase("rp_mg2", 3'd1, L_MG, 6);
    run_phase("rp_my", 3'd2, L_MY, 2);
    run_phase("rp_sg", 3'd4, L_SG, 3);
    reprogram = 1'b1; sel = 2'b10; time_value = 4'd5;
    step();
    reprogram = 1'b0;
    run_phase("ry_mg1", 3'd0, L_MG, 6);
    run_phase("ry_mg2", 3'd1, L_MG, 6);
    run_phase("ry_my", 3'd2, L_MY, 5);
    run_phase("ry_sg", 3'd4, L_SG, 6);
    run_phase("ry_sy", 3'd5, L_SY, 5);
    check("ry_wrap", 32'(phase), 32'd0);

    // Zero tBASE is clamped to one tick
    reprogram = 1'b1; sel = 2'b00; time_value = 4'd0;
    step();
    reprogram = 1'b0;
    run_phase("z_mg1", 3'd0, L_MG, 1);
    run_phase("z_mg2", 3'd1, L_MG, 1);
    run_phase("z_my", 3'd2, L_MY, 5);
    run_phase("z_sg", 3'd4, L_SG, 1);
    run_phase("z_sy", 3'd5, L_SY, 5);

    // Reset wins over Reprogram and restores defaults
    reset = 1'b1; reprogram = 1'b1; sel = 2'b00; time_value = 4'd9;
    step();
    reset = 1'b0; reprogram = 1'b0;
    run_phase("rr_mg1", 3'd0, L_MG, 6);
    run_phase("rr_mg2", 3'd1, L_MG, 6);
    run_phase("rr_my", 3'd2, L_MY, 2);
    check("rr_sg", 32'(phase), 32'd4);

    // Divided tick instance
    reset4 = 1'b1;
    step();
    reset4 = 1'b0;
    count_phase4(3'd0, n);
    check("div_mg1_len", n, 32'd24);
    count_phase4(3'd1, n);
    check("div_mg2_len", n, 32'd24);
    check("div_my_leds", 32'(leds4), 32'(L_MY));
    step(); step(); step();
    reset4 = 1'b1;
    step();
    reset4 = 1'b0;
    check("div_rst_leds", 32'(leds4), 32'(L_MG));
    check("div_rst_phase", 32'(phase4), 32'd0);
    count_phase4(3'd0, n);
    check("div_rst_mg1_len", n, 32'd24);
    check("div_pend", 32'(walk_pending4), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
